// File: rtl/linescanner_sensor_emulator.sv
// Behavioural line-scan sensor: ADC conversion and line readout with a deterministic pixel ramp.
// Optional build macro LINESCAN_EMU_INTEGRATION_EN makes the ramp base follow integration time.
module linescanner_sensor_emulator #(
   parameter int NUM_PIXELS = 64,
   parameter int ADC_CLOCKS = 20,
   parameter int LVAL_DELAY = 2
) (
   input  logic        pixel_clock,
   input  logic        n_reset,
   input  logic        rst_cvc,
   input  logic        rst_cds,
   input  logic        sample,
   input  logic        load_pulse,
   output logic        end_adc,
   output logic        lval,
   output logic [7:0]  data,
   output logic [15:0] line_count,
   output logic        overrun
);

   localparam int PIX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

   typedef enum logic {ADC_IDLE, ADC_CONV} adc_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_DELAY, RD_ACTIVE} rd_state_t;

   adc_state_t       adc_state, adc_state_next;
   rd_state_t        rd_state, rd_state_next;
   logic             sample_q, load_q;
   logic             sample_rise, load_rise, load_take, adc_done;
   logic [7:0]       adc_cnt, adc_cnt_next;
   logic [7:0]       adc_buf, adc_buf_next;
   logic [7:0]       rd_base, rd_base_next;
   logic [7:0]       data_next, base_value;
   logic             adc_valid, adc_valid_next;
   logic             end_adc_next, lval_next, overrun_next;
   logic [3:0]       dly_cnt, dly_cnt_next;
   logic [PIX_W-1:0] pix_cnt, pix_cnt_next;
   logic [15:0]      line_count_next;

   assign sample_rise = sample && !sample_q;
   assign load_rise   = load_pulse && !load_q;
   // A load is only honoured when the readout is idle and a converted line is waiting.
   assign load_take   = load_rise && (rd_state == RD_IDLE) && adc_valid;

`ifdef LINESCAN_EMU_INTEGRATION_EN
   logic [15:0] integ_cnt, integ_latch;

   always_ff @(posedge pixel_clock or negedge n_reset) begin
      if (!n_reset) begin
         integ_cnt   <= '0;
         integ_latch <= '0;
      end else begin
         if (rst_cvc || rst_cds)
            integ_cnt <= '0;
         else if (integ_cnt != 16'hFFFF)
            integ_cnt <= integ_cnt + 16'd1;
         if (sample_rise && (adc_state == ADC_IDLE))
            integ_latch <= integ_cnt;
      end
   end

   assign base_value = (integ_latch > 16'd255) ? 8'hFF : integ_latch[7:0];
`else
   logic [7:0] base_latch;
   logic       unused_integ_resets;

   // The pixel-reset inputs only feed the integration counter, which this build omits.
   assign unused_integ_resets = rst_cvc ^ rst_cds;

   always_ff @(posedge pixel_clock or negedge n_reset) begin
      if (!n_reset)
         base_latch <= '0;
      else if (sample_rise && (adc_state == ADC_IDLE))
         base_latch <= line_count[7:0];
   end

   assign base_value = base_latch;
`endif

   always_comb begin
      adc_state_next = adc_state;
      adc_cnt_next   = adc_cnt;
      adc_buf_next   = adc_buf;
      end_adc_next   = end_adc;
      adc_done       = 1'b0;
      case (adc_state)
         ADC_IDLE: begin
            if (sample_rise) begin
               adc_state_next = ADC_CONV;
               adc_cnt_next   = '0;
               end_adc_next   = 1'b0;
            end
         end
         ADC_CONV: begin
            if (adc_cnt == 8'(ADC_CLOCKS - 1)) begin
               adc_done       = 1'b1;
               adc_state_next = ADC_IDLE;
               end_adc_next   = 1'b1;
               adc_buf_next   = base_value;
            end else begin
               adc_cnt_next = adc_cnt + 8'd1;
            end
         end
         default: adc_state_next = ADC_IDLE;
      endcase
   end

   // Completion wins over a same-cycle take so a fresh result is never dropped.
   always_comb begin
      adc_valid_next = adc_valid;
      if (load_take)
         adc_valid_next = 1'b0;
      if (adc_done)
         adc_valid_next = 1'b1;
   end

   assign overrun_next = overrun
                       | (sample_rise && (adc_state == ADC_CONV))
                       | (adc_done && adc_valid && !load_take)
                       | (load_rise && !load_take);

   always_comb begin
      rd_state_next   = rd_state;
      dly_cnt_next    = dly_cnt;
      pix_cnt_next    = pix_cnt;
      rd_base_next    = rd_base;
      lval_next       = lval;
      data_next       = data;
      line_count_next = line_count;
      case (rd_state)
         RD_IDLE: begin
            if (load_take) begin
               rd_base_next = adc_buf;
               dly_cnt_next = '0;
               pix_cnt_next = '0;
               if (LVAL_DELAY == 0) begin
                  rd_state_next = RD_ACTIVE;
                  lval_next     = 1'b1;
                  data_next     = adc_buf;
               end else begin
                  rd_state_next = RD_DELAY;
               end
            end
         end
         RD_DELAY: begin
            if ({28'd0, dly_cnt} == LVAL_DELAY - 1) begin
               rd_state_next = RD_ACTIVE;
               lval_next     = 1'b1;
               data_next     = rd_base;
            end else begin
               dly_cnt_next = dly_cnt + 4'd1;
            end
         end
         RD_ACTIVE: begin
            if (pix_cnt == PIX_W'(NUM_PIXELS - 1)) begin
               rd_state_next   = RD_IDLE;
               lval_next       = 1'b0;
               data_next       = '0;
               line_count_next = line_count + 16'd1;
            end else begin
               pix_cnt_next = pix_cnt + 1'b1;
               data_next    = rd_base + 8'(pix_cnt) + 8'd1;
            end
         end
         default: rd_state_next = RD_IDLE;
      endcase
   end

   always_ff @(posedge pixel_clock or negedge n_reset) begin
      if (!n_reset) begin
         sample_q   <= 1'b0;
         load_q     <= 1'b0;
         adc_state  <= ADC_IDLE;
         adc_cnt    <= '0;
         adc_buf    <= '0;
         adc_valid  <= 1'b0;
         end_adc    <= 1'b1;
         rd_state   <= RD_IDLE;
         dly_cnt    <= '0;
         pix_cnt    <= '0;
         rd_base    <= '0;
         lval       <= 1'b0;
         data       <= '0;
         line_count <= '0;
         overrun    <= 1'b0;
      end else begin
         sample_q   <= sample;
         load_q     <= load_pulse;
         adc_state  <= adc_state_next;
         adc_cnt    <= adc_cnt_next;
         adc_buf    <= adc_buf_next;
         adc_valid  <= adc_valid_next;
         end_adc    <= end_adc_next;
         rd_state   <= rd_state_next;
         dly_cnt    <= dly_cnt_next;
         pix_cnt    <= pix_cnt_next;
         rd_base    <= rd_base_next;
         lval       <= lval_next;
         data       <= data_next;
         line_count <= line_count_next;
         overrun    <= overrun_next;
      end
   end

endmodule

// File: tb/tb_linescanner_sensor_emulator.sv
// Directed bench for linescanner_sensor_emulator: default instance plus a 300-pixel,
// zero-delay, single-cycle-ADC instance for boundary cases.
module tb_linescanner_sensor_emulator;

   logic        pixel_clock = 1'b0;
   logic        n_reset = 1'b0;
   logic        rst_cvc = 1'b0, rst_cds = 1'b0;
   logic        sample = 1'b0, load_pulse = 1'b0;
   logic        end_adc, lval, overrun;
   logic [7:0]  data;
   logic [15:0] line_count;

   logic        sample2 = 1'b0, load2 = 1'b0;
   logic        end_adc2, lval2, overrun2;
   logic [7:0]  data2;
   logic [15:0] line_count2;

   int checks = 0;
   int errors = 0;

   always #5 pixel_clock = ~pixel_clock;

   linescanner_sensor_emulator dut (
      .pixel_clock(pixel_clock), .n_reset(n_reset), .rst_cvc(rst_cvc), .rst_cds(rst_cds),
      .sample(sample), .load_pulse(load_pulse), .end_adc(end_adc), .lval(lval),
      .data(data), .line_count(line_count), .overrun(overrun)
   );

   linescanner_sensor_emulator #(.NUM_PIXELS(300), .ADC_CLOCKS(1), .LVAL_DELAY(0)) dut_wide (
      .pixel_clock(pixel_clock), .n_reset(n_reset), .rst_cvc(rst_cvc), .rst_cds(rst_cds),
      .sample(sample2), .load_pulse(load2), .end_adc(end_adc2), .lval(lval2),
      .data(data2), .line_count(line_count2), .overrun(overrun2)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      @(negedge pixel_clock);
      sample = 1'b0;
      load_pulse = 1'b0;
      n_reset = 1'b0;
      repeat (2) @(negedge pixel_clock);
      n_reset = 1'b1;
   endtask

   // One-cycle pulse; returns 1ns after the edge that detects the rise.
   task automatic pulse(input logic s, input logic l);
      @(posedge pixel_clock); #1;
      sample = s;
      load_pulse = l;
      @(posedge pixel_clock); #1;
      sample = 1'b0;
      load_pulse = 1'b0;
   endtask

   task automatic wait_adc(output int low);
      low = 0;
      while (end_adc === 1'b0 && low < 300) begin
         low++;
         @(posedge pixel_clock); #1;
      end
   endtask

   task automatic wait_line(input logic [7:0] base, output int dly, output int n, output int bad);
      logic [7:0] exp_d;
      dly = 0;
      n = 0;
      bad = 0;
      while (lval !== 1'b1 && dly < 50) begin
         dly++;
         @(posedge pixel_clock); #1;
      end
      exp_d = base;
      while (lval === 1'b1 && n < 400) begin
         if (data !== exp_d) bad++;
         exp_d = exp_d + 8'd1;
         n++;
         @(posedge pixel_clock); #1;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) @(posedge pixel_clock); #1;
      checks++; if (end_adc !== 1'b1) begin errors++; $display("FAIL reset_end_adc: got %b expected 1", end_adc); end
      checks++; if (lval !== 1'b0) begin errors++; $display("FAIL reset_lval: got %b expected 0", lval); end
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
      checks++; if (line_count !== 16'd0) begin errors++; $display("FAIL reset_line_count: got %0d expected 0", line_count); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      checks++; if (end_adc2 !== 1'b1 || lval2 !== 1'b0) begin errors++; $display("FAIL reset_wide: got end_adc=%b lval=%b expected 1/0", end_adc2, lval2); end
      @(negedge pixel_clock);
      n_reset = 1'b1;
   endtask

   task automatic test_conversion();
      int low;
      pulse(1'b1, 1'b0);
      wait_adc(low);
      checks++; if (low !== 20) begin errors++; $display("FAIL adc_low_cycles: got %0d expected 20", low); end
      checks++; if (end_adc !== 1'b1) begin errors++; $display("FAIL adc_done_high: got %b expected 1", end_adc); end
      checks++; if (lval !== 1'b0) begin errors++; $display("FAIL adc_lval_quiet: got %b expected 0", lval); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL adc_overrun: got %b expected 0", overrun); end
   endtask

   task automatic test_readout();
      int dly, n, bad;
      pulse(1'b0, 1'b1);
      wait_line(8'h00, dly, n, bad);
      checks++; if (dly !== 2) begin errors++; $display("FAIL rd_lval_delay: got %0d expected 2", dly); end
      checks++; if (n !== 64) begin errors++; $display("FAIL rd_pixels: got %0d expected 64", n); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rd_data_ramp0: got %0d bad pixels expected 0", bad); end
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL rd_data_after: got %h expected 00", data); end
      checks++; if (line_count !== 16'd1) begin errors++; $display("FAIL rd_line_count: got %0d expected 1", line_count); end
   endtask

   task automatic test_second_line();
      int low, dly, n, bad;
      pulse(1'b1, 1'b0);
      wait_adc(low);
      pulse(1'b0, 1'b1);
      wait_line(8'h01, dly, n, bad);
      checks++; if (n !== 64 || bad !== 0) begin errors++; $display("FAIL line2_ramp: got n=%0d bad=%0d expected 64/0", n, bad); end
      checks++; if (line_count !== 16'd2) begin errors++; $display("FAIL line2_count: got %0d expected 2", line_count); end
   endtask

   task automatic test_base_wrap();
      int low, dly, n, bad, bad_lines;
      bad_lines = 0;
      for (int i = 2; i < 256; i++) begin
         pulse(1'b1, 1'b0);
         wait_adc(low);
         pulse(1'b0, 1'b1);
         wait_line(8'(i), dly, n, bad);
         if (low != 20 || dly != 2 || n != 64 || bad != 0) bad_lines++;
      end
      checks++; if (bad_lines !== 0) begin errors++; $display("FAIL wrap_lines: got %0d bad lines expected 0", bad_lines); end
      checks++; if (line_count !== 16'd256) begin errors++; $display("FAIL wrap_count: got %0d expected 256", line_count); end
      pulse(1'b1, 1'b0);
      wait_adc(low);
      pulse(1'b0, 1'b1);
      wait_line(8'h00, dly, n, bad);
      checks++; if (n !== 64 || bad !== 0) begin errors++; $display("FAIL wrap_base0: got n=%0d bad=%0d expected 64/0", n, bad); end
      checks++; if (line_count !== 16'd257) begin errors++; $display("FAIL wrap_count2: got %0d expected 257", line_count); end
   endtask

   // Sample and load in the same cycle: readout takes the old buffer while a new conversion runs.
   task automatic test_back_to_back();
      int low, dly, n, bad;
      pulse(1'b1, 1'b0);
      wait_adc(low);
      pulse(1'b1, 1'b1);
      checks++; if (end_adc !== 1'b0) begin errors++; $display("FAIL b2b_conv_started: got %b expected 0", end_adc); end
      wait_line(8'h01, dly, n, bad);
      checks++; if (dly !== 2 || n !== 64 || bad !== 0) begin errors++; $display("FAIL b2b_line_a: got dly=%0d n=%0d bad=%0d expected 2/64/0", dly, n, bad); end
      checks++; if (end_adc !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_state: got end_adc=%b overrun=%b expected 1/0", end_adc, overrun); end
      checks++; if (line_count !== 16'd258) begin errors++; $display("FAIL b2b_count: got %0d expected 258", line_count); end
      pulse(1'b0, 1'b1);
      wait_line(8'h01, dly, n, bad);
      checks++; if (n !== 64 || bad !== 0) begin errors++; $display("FAIL b2b_line_b: got n=%0d bad=%0d expected 64/0", n, bad); end
      checks++; if (line_count !== 16'd259) begin errors++; $display("FAIL b2b_count2: got %0d expected 259", line_count); end
   endtask

   task automatic test_overrun_load_no_conv();
      apply_reset();
      pulse(1'b0, 1'b1);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_load_set: got %b expected 1", overrun); end
      repeat (5) @(posedge pixel_clock); #1;
      checks++; if (lval !== 1'b0) begin errors++; $display("FAIL ovr_load_no_lval: got %b expected 0", lval); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_load_sticky: got %b expected 1", overrun); end
   endtask

   task automatic test_overrun_double_sample();
      int low;
      apply_reset();
      pulse(1'b1, 1'b0);
      repeat (3) @(posedge pixel_clock);
      pulse(1'b1, 1'b0);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sample_set: got %b expected 1", overrun); end
      wait_adc(low);
      checks++; if (low !== 15) begin errors++; $display("FAIL ovr_sample_no_restart: got %0d expected 15", low); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sample_sticky: got %b expected 1", overrun); end
   endtask

   task automatic test_overrun_two_conv();
      int low, dly, n, bad;
      apply_reset();
      pulse(1'b1, 1'b0);
      wait_adc(low);
      pulse(1'b1, 1'b0);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_conv_early: got %b expected 0", overrun); end
      wait_adc(low);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_conv_set: got %b expected 1", overrun); end
      pulse(1'b0, 1'b1);
      wait_line(8'h00, dly, n, bad);
      checks++; if (n !== 64 || bad !== 0) begin errors++; $display("FAIL ovr_conv_line: got n=%0d bad=%0d expected 64/0", n, bad); end
   endtask

   // Load rise on the very edge that finishes the conversion must be rejected.
   task automatic test_completion_load_same_cycle();
      int dly, n, bad;
      apply_reset();
      pulse(1'b1, 1'b0);
      repeat (19) @(posedge pixel_clock);
      #1 load_pulse = 1'b1;
      @(posedge pixel_clock); #1;
      load_pulse = 1'b0;
      checks++; if (end_adc !== 1'b1) begin errors++; $display("FAIL same_cycle_end_adc: got %b expected 1", end_adc); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL same_cycle_overrun: got %b expected 1", overrun); end
      repeat (6) @(posedge pixel_clock); #1;
      checks++; if (lval !== 1'b0) begin errors++; $display("FAIL same_cycle_no_lval: got %b expected 0", lval); end
      pulse(1'b0, 1'b1);
      wait_line(8'h00, dly, n, bad);
      checks++; if (n !== 64 || bad !== 0) begin errors++; $display("FAIL same_cycle_retry: got n=%0d bad=%0d expected 64/0", n, bad); end
   endtask

   task automatic test_reset_mid_readout();
      int low, dly, n, bad, w;
      apply_reset();
      pulse(1'b1, 1'b0);
      wait_adc(low);
      pulse(1'b0, 1'b1);
      w = 0;
      while (lval !== 1'b1 && w < 50) begin
         w++;
         @(posedge pixel_clock); #1;
      end
      pulse(1'b1, 1'b0);
      repeat (8) @(posedge pixel_clock); #1;
      checks++; if (data !== 8'h0A) begin errors++; $display("FAIL mid_pixel10: got %h expected 0a", data); end
      checks++; if (end_adc !== 1'b0) begin errors++; $display("FAIL mid_converting: got %b expected 0", end_adc); end
      n_reset = 1'b0;
      #1;
      checks++; if (lval !== 1'b0 || data !== 8'h00) begin errors++; $display("FAIL mid_reset_out: got lval=%b data=%h expected 0/00", lval, data); end
      checks++; if (end_adc !== 1'b1) begin errors++; $display("FAIL mid_reset_end_adc: got %b expected 1", end_adc); end
      @(negedge pixel_clock);
      n_reset = 1'b1;
      pulse(1'b1, 1'b0);
      wait_adc(low);
      checks++; if (low !== 20) begin errors++; $display("FAIL post_reset_adc: got %0d expected 20", low); end
      pulse(1'b0, 1'b1);
      wait_line(8'h00, dly, n, bad);
      checks++; if (dly !== 2 || n !== 64 || bad !== 0) begin errors++; $display("FAIL post_reset_line: got dly=%0d n=%0d bad=%0d expected 2/64/0", dly, n, bad); end
      checks++; if (line_count !== 16'd1 || overrun !== 1'b0) begin errors++; $display("FAIL post_reset_state: got count=%0d overrun=%b expected 1/0", line_count, overrun); end
   endtask

   task automatic test_wide_line();
      int n, bad;
      logic [7:0] exp_d, d255, d256;
      @(posedge pixel_clock); #1 sample2 = 1'b1;
      @(posedge pixel_clock); #1 sample2 = 1'b0;
      checks++; if (end_adc2 !== 1'b0) begin errors++; $display("FAIL wide_adc_low: got %b expected 0", end_adc2); end
      @(posedge pixel_clock); #1;
      checks++; if (end_adc2 !== 1'b1) begin errors++; $display("FAIL wide_adc_one_cycle: got %b expected 1", end_adc2); end
      @(posedge pixel_clock); #1 load2 = 1'b1;
      @(posedge pixel_clock); #1 load2 = 1'b0;
      checks++; if (lval2 !== 1'b1) begin errors++; $display("FAIL wide_lval_delay0: got %b expected 1", lval2); end
      n = 0;
      bad = 0;
      exp_d = 8'h00;
      d255 = 8'h00;
      d256 = 8'hAA;
      while (lval2 === 1'b1 && n < 400) begin
         if (data2 !== exp_d) bad++;
         if (n == 255) d255 = data2;
         if (n == 256) d256 = data2;
         exp_d = exp_d + 8'd1;
         n++;
         @(posedge pixel_clock); #1;
      end
      checks++; if (n !== 300) begin errors++; $display("FAIL wide_pixels: got %0d expected 300", n); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL wide_ramp: got %0d bad pixels expected 0", bad); end
      checks++; if (d255 !== 8'hFF || d256 !== 8'h00) begin errors++; $display("FAIL wide_wrap: got %h,%h expected ff,00", d255, d256); end
      checks++; if (line_count2 !== 16'd1 || data2 !== 8'h00) begin errors++; $display("FAIL wide_after: got count=%0d data=%h expected 1/00", line_count2, data2); end
   endtask

   initial begin
      test_reset();
      test_wide_line();
      test_conversion();
      test_readout();
      test_second_line();
      test_base_wrap();
      test_back_to_back();
      test_overrun_load_no_conv();
      test_overrun_double_sample();
      test_overrun_two_conv();
      test_completion_load_same_cycle();
      test_reset_mid_readout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
